// File: rtl/e_div_seq_pkg.sv
// Shared constants and state encoding for the e_div_seq iterative divider.
package e_div_seq_pkg;

  // Number of restoring iterations for the default 32-bit datapath.
  localparam int DIV_ITERS = 32;

  // Quotient returned on divide by zero (all ones, both signed and unsigned).
  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/e_div_seq_div_step.sv
// One combinational radix-2 restoring iteration over {prem, q}.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] pq_i,
  input  logic [WIDTH-1:0]   dvs_i,
  output logic [2*WIDTH-1:0] pq_o
);

  logic [WIDTH:0]   sh_hi_s;
  logic [WIDTH-1:0] diff_s;
  logic             ge_s;

  // Shift {prem, q} left, trial-subtract the divisor, keep or restore.
  always_comb begin
    // Partial remainder after the shift, including the bit shifted out of prem.
    sh_hi_s = pq_i[2*WIDTH-1:WIDTH-1];
    ge_s    = (sh_hi_s >= {1'b0, dvs_i});
    // When ge_s holds the true difference is below dvs_i, so WIDTH bits suffice.
    diff_s  = sh_hi_s[WIDTH-1:0] - dvs_i;
    if (ge_s) begin
      pq_o = {diff_s, pq_i[WIDTH-2:0], 1'b1};
    end else begin
      pq_o = {sh_hi_s[WIDTH-1:0], pq_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/e_div_seq.sv
// e_div_seq: iterative radix-2 restoring divider (div/divu) for the EX stage.
// Produces {rem, quo} for the HI/LO unit after WIDTH iterations plus a sign-fix cycle.
// Optional macro DIV_EARLY_OUT_EN: finish divide-by-zero, |a|<|b| and |b|==1 in IDLE.
module e_div_seq
  import e_div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ZERO_QUO = WIDTH'(signed'(DIV_ZERO_QUO));

  // Magnitude of a possibly two's-complement operand.
  function automatic logic [WIDTH-1:0] mag(input logic sgn, input logic [WIDTH-1:0] v);
    if (sgn && v[WIDTH-1]) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   pq_q, pq_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     rem_q, rem_d;

  logic [WIDTH-1:0]     a_mag_s, b_mag_s;
  logic                 qneg_s, rneg_s, dz_s;
  logic [2*WIDTH-1:0]   pq_next_s;

  // Operand magnitudes and result signs as seen at the start edge.
  always_comb begin
    a_mag_s = mag(is_signed, dividend);
    b_mag_s = mag(is_signed, divisor);
    qneg_s  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
    rneg_s  = is_signed & dividend[WIDTH-1];
    dz_s    = (divisor == {WIDTH{1'b0}});
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .pq_i  (pq_q),
    .dvs_i (dvs_q),
    .pq_o  (pq_next_s)
  );

`ifdef DIV_EARLY_OUT_EN
  logic             eo_s;
  logic [WIDTH-1:0] eo_quo_s, eo_rem_s;

  // Trivial cases resolved without iterating; results match the full path.
  always_comb begin
    eo_s = dz_s || (a_mag_s < b_mag_s) || (b_mag_s == {{(WIDTH-1){1'b0}}, 1'b1});
    if (dz_s) begin
      eo_quo_s = ZERO_QUO;
      eo_rem_s = dividend;
    end else if (a_mag_s < b_mag_s) begin
      eo_quo_s = {WIDTH{1'b0}};
      eo_rem_s = dividend;
    end else begin
      eo_quo_s = qneg_s ? -a_mag_s : a_mag_s;
      eo_rem_s = {WIDTH{1'b0}};
    end
  end
`endif

  // Next-state and datapath control; flush overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pq_d    = pq_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    if (flush) begin
      state_d = DIV_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
`ifdef DIV_EARLY_OUT_EN
            if (eo_s) begin
              quo_d  = eo_quo_s;
              rem_d  = eo_rem_s;
              done_d = 1'b1;
            end else begin
              state_d = DIV_CALC;
              busy_d  = 1'b1;
              cnt_d   = {CNT_W{1'b0}};
              pq_d    = {{WIDTH{1'b0}}, a_mag_s};
              dvs_d   = b_mag_s;
              qneg_d  = qneg_s;
              rneg_d  = rneg_s;
              dz_d    = dz_s;
            end
`else
            state_d = DIV_CALC;
            busy_d  = 1'b1;
            cnt_d   = {CNT_W{1'b0}};
            pq_d    = {{WIDTH{1'b0}}, a_mag_s};
            dvs_d   = b_mag_s;
            qneg_d  = qneg_s;
            rneg_d  = rneg_s;
            dz_d    = dz_s;
`endif
          end else begin
            state_d = DIV_IDLE;
          end
        end
        DIV_CALC: begin
          pq_d = pq_next_s;
          if (cnt_q == CNT_LAST) begin
            state_d = DIV_FIX;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DIV_FIX: begin
          // Divide by zero forces all-ones; prem already equals |dividend| there.
          if (dz_q) begin
            quo_d = ZERO_QUO;
          end else begin
            quo_d = qneg_q ? -pq_q[WIDTH-1:0] : pq_q[WIDTH-1:0];
          end
          rem_d   = rneg_q ? -pq_q[2*WIDTH-1:WIDTH] : pq_q[2*WIDTH-1:WIDTH];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DIV_IDLE;
        end
        default: begin
          state_d = DIV_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      pq_q    <= {(2*WIDTH){1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pq_q    <= pq_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quo  = quo_q;
  assign rem  = rem_q;

endmodule

// File: tb/tb_e_div_seq.sv
// Self-checking bench for e_div_seq: vector table, random ops, and multi-cycle corner cases.
module tb_e_div_seq;

  logic        clk = 1'b0;
  logic        reset, start, is_signed, flush;
  logic [31:0] dividend, divisor;
  logic        busy, done;
  logic [31:0] quo, rem;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EO_EN = 1'b1;
`else
  localparam bit EO_EN = 1'b0;
`endif

  e_div_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .busy(busy), .done(done), .quo(quo), .rem(rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_q, last_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tb_mag(input logic s, input logic [31:0] v);
    return (s && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic early(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic e;
    e = (b == 32'd0) || (tb_mag(s, a) < tb_mag(s, b)) || (tb_mag(s, b) == 32'd1);
    return e & EO_EN;
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got quo %h rem %h with no result pending", quo, rem);
      end else begin
        mon_e = sb_q.pop_front();
        chk("quo", quo, mon_e.q);
        chk("rem", rem, mon_e.r);
      end
    end
  end

  // Drive one start pulse (called away from the rising edge); returns just after E0.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic push, input logic [31:0] q, input logic [31:0] r);
    exp_t e;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    if (push) begin
      e.q = q;
      e.r = r;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait for done, measuring edges since the start edge and checking busy on the way.
  task automatic wait_done(input string name, input int exp_lat, input logic exp_busy);
    int   n;
    logic got;
    logic busy_ok;
    n = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    while (n <= 60) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (busy !== exp_busy) busy_ok = 1'b0;
      @(posedge clk);
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done within 60 cycles, required done", name);
      sb_q.delete();
    end else begin
      chk({name, "_latency"}, 32'(n), 32'(exp_lat));
      chk({name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    end
    chk({name, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] q, input logic [31:0] r);
    logic eo;
    eo = early(s, a, b);
    launch(s, a, b, 1'b1, q, r);
    wait_done(name, eo ? 0 : 33, eo ? 1'b0 : 1'b1);
    last_q = q;
    last_r = r;
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5};
    vecs[4]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
    vecs[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF};
    vecs[8]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'h00010000,   32'h0000FFFF,   32'h0000FFFF};
    vecs[10] = '{1'b0, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2};
    vecs[11] = '{1'b1, 32'hFFFFFFF9,   32'd1,          32'hFFFFFFF9,   32'd0};
    vecs[12] = '{1'b0, 32'hDEADBEEF,   32'hDEADBEEF,   32'd1,          32'd0};

    reset = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
    dividend = 32'd0; divisor = 32'd0;
    last_q = 32'd0; last_r = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quo", quo, 32'd0);
    chk("reset_rem", rem, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
      @(negedge clk);
    end

    // Random operations against the language's own / and % operators.
    for (int i = 0; i < 10; i++) begin
      logic        s;
      logic [31:0] a, b, q, r;
      s = i[0];
      a = $urandom;
      b = $urandom >> $urandom_range(0, 30);
      if (b == 32'd0) b = 32'd3;
      if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
      run_op($sformatf("rnd%0d", i), s, a, b, q, r);
      @(negedge clk);
    end

    // Flush mid-operation: busy drops, no done, outputs hold.
    launch(1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_hold_quo", quo, last_q);
    chk("flush_hold_rem", rem, last_r);
    run_op("after_flush", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
    @(negedge clk);

    // Start while busy is ignored.
    launch(1'b0, 32'd1000, 32'd7, 1'b1, 32'd142, 32'd6);
    repeat (5) @(negedge clk);
    launch(1'b0, 32'd20, 32'd6, 1'b0, 32'd0, 32'd0);
    wait_done("ignored_start", 28, 1'b1);
    repeat (40) @(negedge clk);

    // Back-to-back: start in the done cycle is accepted.
    launch(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
    wait_done("b2b_first", 33, 1'b1);
    launch(1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0);
    wait_done("b2b_second", 33, 1'b1);
    @(negedge clk);

    // Reset during CALC clears everything; next op runs normally.
    launch(1'b0, 32'd1000, 32'd7, 1'b0, 32'd0, 32'd0);
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_quo", quo, 32'd0);
    chk("rst_mid_rem", rem, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run_op("after_reset", 1'b0, 32'd8, 32'd2, 32'd4, 32'd0);
    repeat (5) @(negedge clk);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
